alu_mc: RTL and testbench

//  Multi-cycle, width-parametrised ALU. Next generation of the single-cycle core ALU.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_iter_unit.sv | 88 ++++++++
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and iteration-mode definitions for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SHL  = 4'b0001,
        OP_SHR  = 4'b0010,
        OP_MOV  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_ADDI = 4'b0111,
        OP_BNE  = 4'b1000,
        OP_BEQ  = 4'b1001,
        OP_MOVI = 4'b1010,
        OP_MUL  = 4'b1011,
        OP_CMP  = 4'b1101,
        OP_NOP  = 4'b1111
    } op_t;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t MUL   = 2'd2;
    localparam state_t DONE  = 2'd3;

    typedef logic [1:0] iter_mode_t;

    localparam iter_mode_t MODE_SHL = 2'd0;
    localparam iter_mode_t MODE_SHR = 2'd1;
    localparam iter_mode_t MODE_MUL = 2'd2;

    function automatic logic is_shift(input op_t op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifts and, with ALU_MC_MUL_EN defined, a shift-add
// multiplier. acc/last_out present the value the accumulator takes after the current step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] op_a,
`ifdef ALU_MC_MUL_EN
    input  logic [WIDTH-1:0] op_b,
`endif
    input  logic             fill,
    output logic [WIDTH-1:0] acc,
    output logic             last_out
);

    logic [WIDTH-1:0] acc_q;
    iter_mode_t       mode_q;
    logic             fill_q;

`ifdef ALU_MC_MUL_EN
    // Multiplier keeps the running high half in hi_q; the low half shifts into acc_q
    // as the multiplier bits are consumed from its LSB.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH:0]   mul_sum;
`endif

    always_comb begin
        acc      = acc_q;
        last_out = 1'b0;
`ifdef ALU_MC_MUL_EN
        mul_sum  = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        hi_nxt   = mul_sum[WIDTH:1];
`endif
        case (mode_q)
            MODE_SHL: begin
                acc      = {acc_q[WIDTH-2:0], fill_q};
                last_out = acc_q[WIDTH-1];
            end
            MODE_SHR: begin
                acc      = {fill_q, acc_q[WIDTH-1:1]};
                last_out = acc_q[0];
            end
`ifdef ALU_MC_MUL_EN
            MODE_MUL: begin
                acc      = {mul_sum[0], acc_q[WIDTH-1:1]};
                last_out = |hi_nxt;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mode_q  <= MODE_SHL;
            fill_q  <= 1'b0;
`ifdef ALU_MC_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (load) begin
            mode_q  <= mode;
            fill_q  <= fill;
`ifdef ALU_MC_MUL_EN
            acc_q   <= (mode == MODE_MUL) ? op_b : op_a;
            hi_q    <= '0;
            mcand_q <= op_a;
`else
            acc_q   <= op_a;
`endif
        end else if (step) begin
            acc_q   <= acc;
`ifdef ALU_MC_MUL_EN
            hi_q    <= hi_nxt;
`endif
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides; result and flags are registered.
// Build option ALU_MC_MUL_EN enables the iterative MUL opcode (otherwise it decodes as NOP).
//
// state | meaning
// IDLE  | waiting for an op, in_ready high
// SHIFT | shifting one bit per cycle, cnt steps remaining
// MUL   | shift-add multiply, cnt steps remaining
// DONE  | out_valid high, result held until out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             pari,
    output logic             zero,
    output logic             equal
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_t              op;
    logic             accept;
    logic [CNT_W-1:0] shift_cnt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] res_r;
    logic             res_c;
    logic             iter_start;
    iter_mode_t       iter_mode;
    state_t           iter_st;
    logic [CNT_W-1:0] iter_cnt;
    logic [WIDTH-1:0] it_acc;
    logic             it_last;

    assign op        = op_t'(alu_cmd);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign shift_cnt = (inB >= WIDTH_V) ? CNT_MAX : inB[CNT_W-1:0];
    assign add_sum   = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, sc_i};

    // Single-cycle results, plus the launch parameters for iterative ops.
    always_comb begin
        res_r      = '0;
        res_c      = 1'b0;
        iter_start = 1'b0;
        iter_mode  = MODE_SHL;
        iter_st    = SHIFT;
        iter_cnt   = shift_cnt;
        case (op)
            OP_ADD, OP_ADDI: {res_c, res_r} = add_sum;
            OP_SHL, OP_SHR: begin
                iter_mode = (op == OP_SHR) ? MODE_SHR : MODE_SHL;
                if (shift_cnt == '0) res_r = inA;
                else                 iter_start = 1'b1;
            end
            OP_MOV, OP_MOVI: res_r = inA;
            OP_OR:           res_r = inA | inB;
            OP_XOR:          res_r = inA ^ inB;
            OP_AND:          res_r = inA & inB;
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
                iter_start = 1'b1;
                iter_mode  = MODE_MUL;
                iter_st    = MUL;
                iter_cnt   = CNT_MAX;
            end
`endif
            default: ;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && iter_start),
        .step     ((state == SHIFT) || (state == MUL)),
        .mode     (iter_mode),
        .op_a     (inA),
`ifdef ALU_MC_MUL_EN
        .op_b     (inB),
`endif
        .fill     (sc_i),
        .acc      (it_acc),
        .last_out (it_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rslt  <= '0;
            sc_o  <= 1'b0;
            pari  <= 1'b0;
            zero  <= 1'b0;
            equal <= 1'b0;
        end else begin
            case (state)
                SHIFT, MUL: begin
                    cnt <= cnt - CNT_W'(1);
                    // The final step's value is registered directly so latency is count+1.
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        rslt  <= it_acc;
                        sc_o  <= it_last;
                        pari  <= ^it_acc;
                        zero  <= (it_acc == '0);
                    end
                end
                default: begin
                    if (accept) begin
                        equal <= (inA == inB);
                        if (is_shift(op) && iter_start) begin
                            state <= iter_st;
                            cnt   <= iter_cnt;
                        end else if (iter_start) begin
                            state <= iter_st;
                            cnt   <= iter_cnt;
                        end else begin
                            state <= DONE;
                            rslt  <= res_r;
                            sc_o  <= res_c;
                            pari  <= ^res_r;
                            zero  <= (res_r == '0);
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): arithmetic reference model with a scoreboard
// checked every cycle, plus directed vectors with literal expected values.
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_cmd = 4'h0;
    logic [7:0] inA = 8'h00;
    logic [7:0] inB = 8'h00;
    logic       sc_i = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] rslt;
    logic       sc_o, pari, zero, equal;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acc_dir = 0;
    int lat;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       eq;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t q[$];

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
        .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt),
        .sc_o(sc_o), .pari(pari), .zero(zero), .equal(equal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input int acc_cyc);
        exp_t e;
        logic [8:0]  sum9;
        logic [15:0] w16;
        logic [7:0]  ff;
        int          n;
        e.r = 8'h00; e.c = 1'b0; e.eq = (a == b); e.lat = 1; e.acc_cyc = acc_cyc;
        n = (b > 8'd8) ? 8 : int'(b);
        ff = 8'hFF;
        case (op)
            OP_ADD, OP_ADDI: begin
                sum9 = 9'(a) + 9'(b) + 9'(s);
                e.r = sum9[7:0]; e.c = sum9[8];
            end
            OP_SHL: begin
                e.r = a;
                if (n > 0) begin
                    w16 = {8'h00, a} << n;
                    e.r = w16[7:0] | (s ? 8'((1 << n) - 1) : 8'h00);
                    e.c = w16[8];
                    e.lat = n + 1;
                end
            end
            OP_SHR: begin
                e.r = a;
                if (n > 0) begin
                    w16 = {a, 8'h00} >> n;
                    ff = ff >> n;
                    e.r = w16[15:8] | (s ? ~ff : 8'h00);
                    e.c = w16[7];
                    e.lat = n + 1;
                end
            end
            OP_MOV, OP_MOVI: e.r = a;
            OP_OR:  e.r = a | b;
            OP_XOR: e.r = a ^ b;
            OP_AND: e.r = a & b;
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
                w16 = 16'(a) * 16'(b);
                e.r = w16[7:0]; e.c = |w16[15:8]; e.lat = 9;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard bookkeeping: consume, then accept, on each edge.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst_n) q.delete();
        else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(alu_cmd, inA, inB, sc_i, cycle + 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || (out_valid && out_ready)));
            if (q.size() == 0) chk("idle_out_valid", 32'(out_valid), 32'd0);
            else begin
                chk("out_valid_timing", 32'(out_valid),
                    32'((cycle - q[0].acc_cyc + 1) >= q[0].lat));
                if (out_valid) begin
                    chk("m_rslt", 32'(rslt), 32'(q[0].r));
                    chk("m_sc_o", 32'(sc_o), 32'(q[0].c));
                    chk("m_pari", 32'(pari), 32'(^q[0].r));
                    chk("m_zero", 32'(zero), 32'(q[0].r == 8'h00));
                    chk("m_equal", 32'(equal), 32'(q[0].eq));
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic s);
        int n = 0;
        alu_cmd = op; inA = a; inB = b; sc_i = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_dir = cycle;
        in_valid = 1'b0;
        inA = 8'($urandom); inB = 8'($urandom); sc_i = 1'($urandom);
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_valid(output int l);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
        l = cycle - acc_dir + 1;
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic s);
        send(op, a, b, s);
        wait_valid(lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rslt", 32'(rslt), 32'd0);
        chk("rst_flags", {28'd0, sc_o, pari, zero, equal}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(OP_ADD, 8'h01, 8'h02, 1'b0);
        wait_valid(lat);
        chk("add1_lat", 32'(lat), 32'd1);
        chk("add1_rslt", 32'(rslt), 32'h03);
        chk("add1_flags", {29'd0, sc_o, zero, pari}, 32'd0);
        @(posedge clk); #1;

        send(OP_ADD, 8'hFF, 8'h01, 1'b0);
        wait_valid(lat);
        chk("add2_rslt", 32'(rslt), 32'h00);
        chk("add2_sc_zero_pari", {29'd0, sc_o, zero, pari}, 32'b110);
        @(posedge clk); #1;

        send(OP_SHL, 8'h81, 8'd3, 1'b0);
        wait_valid(lat);
        chk("shl_lat", 32'(lat), 32'd4);
        chk("shl_rslt", 32'(rslt), 32'h08);
        chk("shl_sc_o", 32'(sc_o), 32'd0);
        @(posedge clk); #1;

        send(OP_SHR, 8'hA5, 8'd9, 1'b0);
        wait_valid(lat);
        chk("shr9_lat", 32'(lat), 32'd9);
        chk("shr9_rslt", 32'(rslt), 32'h00);
        chk("shr9_sc_o", 32'(sc_o), 32'd1);
        @(posedge clk); #1;

        send(OP_SHR, 8'h80, 8'd2, 1'b1);
        wait_valid(lat);
        chk("shr_fill_rslt", 32'(rslt), 32'hE0);
        @(posedge clk); #1;

        send(OP_SHR, 8'h81, 8'd0, 1'b1);
        wait_valid(lat);
        chk("shr0_lat", 32'(lat), 32'd1);
        chk("shr0_rslt", 32'(rslt), 32'h81);
        chk("shr0_sc_o", 32'(sc_o), 32'd0);
        @(posedge clk); #1;

        run(OP_ADDI, 8'h10, 8'h20, 1'b1);
        run(OP_SHL, 8'h3C, 8'd8, 1'b1);
        run(OP_SHL, 8'h55, 8'd1, 1'b1);
        run(OP_SHR, 8'h01, 8'd1, 1'b0);
        run(OP_MOV, 8'h5A, 8'h00, 1'b1);
        run(OP_MOVI, 8'h00, 8'h00, 1'b0);
        run(OP_OR, 8'hA0, 8'h05, 1'b0);
        run(OP_AND, 8'hF0, 8'h3C, 1'b0);
        run(OP_CMP, 8'h44, 8'h44, 1'b1);
        run(OP_BNE, 8'h44, 8'h45, 1'b0);
        run(OP_NOP, 8'h12, 8'h12, 1'b1);
        run(4'b1100, 8'hFF, 8'hFF, 1'b1);

        // Result held under backpressure while a new op waits.
        out_ready = 1'b0;
        send(OP_XOR, 8'h0C, 8'h02, 1'b0);
        wait_valid(lat);
        @(posedge clk); #1;
        alu_cmd = OP_BEQ; inA = 8'h01; inB = 8'h01; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rslt", 32'(rslt), 32'h0E);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_equal", 32'(equal), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("beq_valid", 32'(out_valid), 32'd1);
        chk("beq_equal", 32'(equal), 32'd1);
        chk("beq_rslt", 32'(rslt), 32'h00);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a shift.
        run(OP_MOV, 8'h5B, 8'h5B, 1'b0);
        send(OP_SHR, 8'h80, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rslt", 32'(rslt), 32'd0);
        chk("arst_flags", {28'd0, sc_o, pari, zero, equal}, 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_rslt", 32'(rslt), 32'd0);
        @(posedge clk); #1;

`ifdef ALU_MC_MUL_EN
        send(OP_MUL, 8'd13, 8'd11, 1'b0);
        wait_valid(lat);
        chk("mul_lat", 32'(lat), 32'd9);
        chk("mul_rslt", 32'(rslt), 32'h8F);
        chk("mul_sc_o", 32'(sc_o), 32'd0);
        @(posedge clk); #1;
        send(OP_MUL, 8'h20, 8'h10, 1'b0);
        wait_valid(lat);
        chk("mul_ovf_rslt", 32'(rslt), 32'h00);
        chk("mul_ovf_sc_o", 32'(sc_o), 32'd1);
        @(posedge clk); #1;
        run(OP_MUL, 8'hFF, 8'hFF, 1'b1);
`else
        send(OP_MUL, 8'd13, 8'd11, 1'b0);
        wait_valid(lat);
        chk("mul_off_lat", 32'(lat), 32'd1);
        chk("mul_off_rslt", 32'(rslt), 32'h00);
        @(posedge clk); #1;
`endif

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
